// File: rtl/iter_alu.sv
// Registered ALU with an iterative signed/unsigned multiply/divide unit producing HI/LO results.
// Latency: single-cycle ops 1 edge; MULT/MULTU/DIV/DIVU WIDTH+2 edges (start edge included).
// Backpressure: start accepted only while busy=0 (IDLE or DONE); starts while busy are dropped, never queued.
// Ports: clk, reset (async active-high), start/op/a/b issue, busy, done pulse, y (LO), hi, zero, divzero.
module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             divzero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             b_zero;
    logic             neg_q;   // quotient / product must be negated in FIX
    logic             neg_r;   // remainder takes the sign of a
    logic [WIDTH-1:0] mb;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0] ph;      // product high half / partial remainder
    logic [WIDTH-1:0] pl;      // multiplier -> product low half / dividend -> quotient

    // Single-cycle datapath
    logic [WIDTH-1:0] sum, diff, sc_y;
    logic             slt;

    always_comb begin
        sum  = a + b;
        diff = a - b;
        // Sign of a-b, flipped when the subtraction overflowed
        slt  = diff[WIDTH-1] ^ ((a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]));
        case (op)
            4'b0000: sc_y = a & b;
            4'b0001: sc_y = a | b;
            4'b0010: sc_y = sum;
            4'b0110: sc_y = diff;
            4'b0111: sc_y = {{(WIDTH-1){1'b0}}, slt};
            default: sc_y = '0;
        endcase
    end

    // Operand capture for the iterative unit; op[0]=0 selects the signed variant
    logic             is_md, neg_a_in, neg_b_in;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        is_md    = (op[3:2] == 2'b10);
        neg_a_in = ~op[0] & a[WIDTH-1];
        neg_b_in = ~op[0] & b[WIDTH-1];
        mag_a    = neg_a_in ? -a : a;
        mag_b    = neg_b_in ? -b : b;
    end

    // One iteration step of each algorithm
    logic [WIDTH:0]   madd;
    logic [WIDTH:0]   dshift;
    logic [WIDTH-1:0] dsub;
    logic             dge;

    always_comb begin
        madd   = {1'b0, ph} + (pl[0] ? {1'b0, mb} : '0);
        dshift = {ph, pl[WIDTH-1]};
        dge    = (dshift >= {1'b0, mb});
        // When dge holds the true difference is < mb, so the low WIDTH bits are exact
        dsub   = dshift[WIDTH-1:0] - mb;
    end

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, fix_y, fix_hi;

    always_comb begin
        prod_fix = neg_q ? -{ph, pl} : {ph, pl};
        // Divide by zero: the quotient bits are all ones already, but force them in case
        // a signed op asked for negation; ph holds |a| so the sign fix restores a itself.
        q_fix    = b_zero ? '1 : (neg_q ? -pl : pl);
        r_fix    = neg_r ? -ph : ph;
        fix_y    = is_div ? q_fix : prod_fix[WIDTH-1:0];
        fix_hi   = is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            b_zero  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            mb      <= '0;
            ph      <= '0;
            pl      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            y       <= '0;
            hi      <= '0;
            zero    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        if (is_md) begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            is_div <= op[1];
                            b_zero <= (b == '0);
                            neg_q  <= neg_a_in ^ neg_b_in;
                            neg_r  <= neg_a_in;
                            mb     <= mag_b;
                            ph     <= '0;
                            pl     <= mag_a;
                        end else begin
                            state   <= DONE;
                            done    <= 1'b1;
                            y       <= sc_y;
                            hi      <= '0;
                            zero    <= (sc_y == '0);
                            divzero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (is_div) begin
                        ph <= dge ? dsub : dshift[WIDTH-1:0];
                        pl <= {pl[WIDTH-2:0], dge};
                    end else begin
                        ph <= madd[WIDTH:1];
                        pl <= {madd[0], pl[WIDTH-1:1]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    state   <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    y       <= fix_y;
                    hi      <= fix_hi;
                    zero    <= (fix_y == '0);
                    divzero <= is_div & b_zero;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
module tb_iter_alu;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy, done, zero, divzero;
    logic [31:0] y, hi;

    logic        start8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, zero8, divzero8;
    logic [7:0]  y8, hi8;

    int checks = 0;
    int errors = 0;

    iter_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .y(y), .hi(hi), .zero(zero), .divzero(divzero)
    );

    iter_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .y(y8), .hi(hi8), .zero(zero8), .divzero(divzero8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {divzero, hi, y}
    function automatic logic [64:0] ref_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z);
        logic [31:0]     ry, rh;
        logic            dz;
        longint          sp;
        longint unsigned up;
        ry = '0; rh = '0; dz = 1'b0;
        case (o)
            4'd0:  ry = x & z;
            4'd1:  ry = x | z;
            4'd2:  ry = x + z;
            4'd6:  ry = x - z;
            4'd7:  ry = ($signed(x) < $signed(z)) ? 32'd1 : 32'd0;
            4'd8: begin
                sp = longint'($signed(x)) * longint'($signed(z));
                ry = sp[31:0]; rh = sp[63:32];
            end
            4'd9: begin
                up = longint'(x) * longint'(z);
                ry = up[31:0]; rh = up[63:32];
            end
            4'd10: begin
                if (z == 32'd0) begin
                    ry = 32'hFFFFFFFF; rh = x; dz = 1'b1;
                end else if (x == 32'h80000000 && z == 32'hFFFFFFFF) begin
                    ry = 32'h80000000; rh = 32'd0;
                end else begin
                    ry = $signed(x) / $signed(z);
                    rh = $signed(x) % $signed(z);
                end
            end
            4'd11: begin
                if (z == 32'd0) begin
                    ry = 32'hFFFFFFFF; rh = x; dz = 1'b1;
                end else begin
                    ry = x / z; rh = x % z;
                end
            end
            default: begin ry = '0; rh = '0; end
        endcase
        return {dz, rh, ry};
    endfunction

    // Issue one op on the 32-bit DUT (called just after a rising edge) and check the result
    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z, input string tag);
        logic [64:0] e;
        int          lat, exp_lat;
        logic        md;
        e       = ref_op(o, x, z);
        md      = (o >= 4'd8 && o <= 4'd11);
        exp_lat = md ? 34 : 1;
        start = 1'b1; op = o; a = x; b = z;
        @(posedge clk); #1;
        start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        chk({tag, ".busy_run"}, 64'(busy), 64'(md));
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".y"}, 64'(y), 64'(e[31:0]));
        chk({tag, ".hi"}, 64'(hi), 64'(e[63:32]));
        chk({tag, ".zero"}, 64'(zero), 64'(e[31:0] == 32'd0));
        chk({tag, ".divzero"}, 64'(divzero), 64'(e[64]));
        chk({tag, ".busy_done"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners[0] = 32'd0;          corners[1] = 32'd1;
        corners[2] = 32'hFFFFFFFF;   corners[3] = 32'h80000000;
        corners[4] = 32'h7FFFFFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int n, dn, lat;

        // Reset state
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.y", 64'(y), 64'd0);
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.zero", 64'(zero), 64'd0);
        chk("rst.divzero", 64'(divzero), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Give y a nonzero value, then abort a MULT with an asynchronous reset mid-RUN
        do_op(4'd1, 32'd5, 32'd3, "or_pre");
        start = 1'b1; op = 4'd8; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        chk("abort.y", 64'(y), 64'd0);
        chk("abort.hi", 64'(hi), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        chk("abort.no_done", 64'(dn), 64'd0);

        // Directed cases
        do_op(4'd6, 32'd5, 32'd5, "sub_eq");
        do_op(4'd7, 32'hFFFFFFFF, 32'd1, "slt_neg");
        do_op(4'd7, 32'h80000000, 32'd1, "slt_ovf");
        do_op(4'd7, 32'h7FFFFFFF, 32'hFFFFFFFF, "slt_ovf2");
        do_op(4'd2, 32'hFFFFFFFF, 32'd1, "add_wrap");
        do_op(4'd8, 32'hFFFFFFFD, 32'd7, "mult_neg");
        chk("mult_neg.const", {hi, y}, 64'hFFFFFFFF_FFFFFFEB);
        do_op(4'd9, 32'hFFFFFFFF, 32'd2, "multu");
        chk("multu.const", {hi, y}, 64'h00000001_FFFFFFFE);
        do_op(4'd10, 32'hFFFFFFF9, 32'd2, "div_neg");
        do_op(4'd11, 32'd7, 32'd0, "divu_zero");
        do_op(4'd0, 32'hF0F0F0F0, 32'h0FF00FF0, "and_clr_dz");
        do_op(4'd10, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        do_op(4'd10, 32'hFFFFFFF9, 32'd0, "div_zero_s");
        do_op(4'd13, 32'd12, 32'd34, "undef_op");

        // start held high with changing operands during a DIVU; next op issued in DONE cycle
        start = 1'b1; op = 4'd11; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        n = 1; dn = 0;
        while (dn == 0 && n < 60) begin
            op = 4'($urandom_range(8, 11)); a = $urandom; b = $urandom;
            @(posedge clk); #1;
            n++;
            if (done) dn = 1;
        end
        chk("held.latency", 64'(n), 64'd34);
        chk("held.y", 64'(y), 64'd14);
        chk("held.hi", 64'(hi), 64'd2);
        op = 4'd2; a = 32'd10; b = 32'd20;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b.done", 64'(done), 64'd1);
        chk("b2b.y", 64'(y), 64'd30);
        chk("b2b.busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("b2b.done_low", 64'(done), 64'd0);

        // WIDTH=8 instance
        start8 = 1'b1; op8 = 4'd8; a8 = 8'h80; b8 = 8'h80;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("w8.busy", 64'(busy8), 64'd1);
        lat = 1;
        while (!done8 && lat < 30) begin @(posedge clk); #1; lat++; end
        chk("w8mult.latency", 64'(lat), 64'd10);
        chk("w8mult.prod", 64'({hi8, y8}), 64'h4000);
        chk("w8mult.zero", 64'(zero8), 64'd1);
        start8 = 1'b1; op8 = 4'd10; a8 = 8'h80; b8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 30) begin @(posedge clk); #1; lat++; end
        chk("w8div.latency", 64'(lat), 64'd10);
        chk("w8div.res", 64'({hi8, y8}), 64'h0080);
        chk("w8div.divzero", 64'(divzero8), 64'd0);

        // Random ops against the reference model
        for (int i = 0; i < 2000; i++) begin
            do_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand(), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
